// File: rtl/uart_rx_ctrl_if.sv
// Received-frame bus from the UART receiver to the Rx FIFO controller.
// Level/strobe outputs only; the consumer re-synchronises them, so there is no backpressure.
interface uart_rx_ctrl_if;
  logic       RxBusy;
  logic       RxDone;
  logic [7:0] RxData;
  logic       ParityError;
  logic       FramingError;
  logic       BreakInt;

  modport master (
    output RxBusy, RxDone, RxData, ParityError, FramingError, BreakInt
  );

  modport slave (
    input RxBusy, RxDone, RxData, ParityError, FramingError, BreakInt
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive front end: 16x oversampling, 2-flop RXD sync, result one clock after the stop sample.
// No backpressure: RxDone is stretched for DONE_HOLD clocks and results hold until the next frame.
module uart_rx_ctrl #(
  parameter int DIV_W     = 16,
  parameter int DONE_HOLD = 8
) (
  input  logic             UART_CLK,
  input  logic             RESETn,
  input  logic             RxEn,
  input  logic [DIV_W-1:0] BAUD_DIV,
  input  logic [1:0]       DataBits,
  input  logic             ParityEn,
  input  logic             ParityEven,
  input  logic             RXD,
  uart_rx_ctrl_if.master   rx
);

  localparam int HOLD_W = 7;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state_q, state_d;
  logic               rxd_s1_q, rxd_s1_d;
  logic               rxd_s2_q, rxd_s2_d;
  logic               rxd_prev_q, rxd_prev_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]         samp_cnt_q, samp_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_bit_q, par_bit_d;
  logic [1:0]         cfg_bits_q, cfg_bits_d;
  logic               cfg_pen_q, cfg_pen_d;
  logic               cfg_peven_q, cfg_peven_d;
  logic               armed_q, armed_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [7:0]         data_q, data_d;
  logic               pe_q, pe_d;
  logic               fe_q, fe_d;
  logic               bi_q, bi_d;

  logic               tick;
  logic               samp;
  logic               fall;
  logic [2:0]         last_bit;
  logic [7:0]         data_al;

  always_comb begin
    rxd_s1_d    = RXD;
    rxd_s2_d    = rxd_s1_q;
    rxd_prev_d  = rxd_s2_q;
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    samp_cnt_d  = samp_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    cfg_bits_d  = cfg_bits_q;
    cfg_pen_d   = cfg_pen_q;
    cfg_peven_d = cfg_peven_q;
    armed_d     = armed_q;
    busy_d      = busy_q;
    done_d      = done_q;
    hold_d      = hold_q;
    data_d      = data_q;
    pe_d        = pe_q;
    fe_d        = fe_q;
    bi_d        = bi_q;

    tick     = RxEn && (div_cnt_q == '0);
    samp     = tick && (state_q != IDLE) && (samp_cnt_q == 4'd7);
    fall     = rxd_prev_q && !rxd_s2_q;
    last_bit = 3'd4 + {1'b0, cfg_bits_q};

    // Data bits arrive LSB first into the top of the shifter; right-align by frame width.
    case (cfg_bits_q)
      2'b00:   data_al = {3'b000, shift_q[7:3]};
      2'b01:   data_al = {2'b00,  shift_q[7:2]};
      2'b10:   data_al = {1'b0,   shift_q[7:1]};
      default: data_al = shift_q;
    endcase

    if (RxEn) begin
      div_cnt_d = tick ? BAUD_DIV : div_cnt_q - DIV_W'(1);
    end else begin
      div_cnt_d = '0;
    end
    if (tick && state_q != IDLE) begin
      samp_cnt_d = samp_cnt_q + 4'd1;
    end

    if (rxd_s2_q) begin
      armed_d = 1'b1;
    end

    if (done_q) begin
      if (hold_q == '0) begin
        done_d = 1'b0;
      end else begin
        hold_d = hold_q - HOLD_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (RxEn && armed_q && fall) begin
          state_d     = START;
          busy_d      = 1'b1;
          cfg_bits_d  = DataBits;
          cfg_pen_d   = ParityEn;
          cfg_peven_d = ParityEven;
          div_cnt_d   = BAUD_DIV;
          samp_cnt_d  = 4'd0;
          bit_cnt_d   = 3'd0;
          par_bit_d   = 1'b0;
        end
      end
      START: begin
        if (samp) begin
          if (rxd_s2_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (samp) begin
          shift_d = {rxd_s2_q, shift_q[7:1]};
          if (bit_cnt_q == last_bit) begin
            state_d = cfg_pen_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (samp) begin
          par_bit_d = rxd_s2_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (samp) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hold_d  = HOLD_W'(DONE_HOLD - 1);
          data_d  = data_al;
          pe_d    = cfg_pen_q && ((^data_al ^ par_bit_q) != !cfg_peven_q);
          fe_d    = !rxd_s2_q;
          bi_d    = (data_al == 8'h00) && !(cfg_pen_q && par_bit_q) && !rxd_s2_q;
          if (!rxd_s2_q) begin
            armed_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable abandons the frame but lets a running RxDone hold finish.
    if (!RxEn) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      samp_cnt_d = 4'd0;
      bit_cnt_d  = 3'd0;
    end
  end

  always_ff @(posedge UART_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= IDLE;
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      rxd_prev_q  <= 1'b1;
      div_cnt_q   <= '0;
      samp_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_bit_q   <= 1'b0;
      cfg_bits_q  <= 2'b00;
      cfg_pen_q   <= 1'b0;
      cfg_peven_q <= 1'b0;
      armed_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hold_q      <= '0;
      data_q      <= 8'h00;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
      bi_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rxd_s1_q    <= rxd_s1_d;
      rxd_s2_q    <= rxd_s2_d;
      rxd_prev_q  <= rxd_prev_d;
      div_cnt_q   <= div_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      cfg_bits_q  <= cfg_bits_d;
      cfg_pen_q   <= cfg_pen_d;
      cfg_peven_q <= cfg_peven_d;
      armed_q     <= armed_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hold_q      <= hold_d;
      data_q      <= data_d;
      pe_q        <= pe_d;
      fe_q        <= fe_d;
      bi_q        <= bi_d;
    end
  end

  assign rx.RxBusy       = busy_q;
  assign rx.RxDone       = done_q;
  assign rx.RxData       = data_q;
  assign rx.ParityError  = pe_q;
  assign rx.FramingError = fe_q;
  assign rx.BreakInt     = bi_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Serial receive front end of the UART. Oversamples the RXD line at 16x the baud rate, deframes start, data, optional parity and stop bits, and presents each received byte with a held RxDone strobe and a RxBusy level. It sits directly upstream of the Rx FIFO controller, which double-syncs RxBusy, RxDone and RxData and pushes the byte on the RxDone rising edge.

Parameters:
DIV_W, 16, width of the baud divisor.
DONE_HOLD, 8, number of UART_CLK cycles RxDone stays high per frame (range 4..64); long enough for a slower consumer clock to capture the edge through two flops.

Ports:
UART_CLK  in  1  block clock; all logic runs on the rising edge.
RESETn  in  1  asynchronous active-low reset.
RxEn  in  1  receiver enable; low forces IDLE.
BAUD_DIV  in  DIV_W  sample tick every BAUD_DIV+1 clocks (16 ticks per bit).
DataBits  in  2  00=5, 01=6, 10=7, 11=8 data bits.
ParityEn  in  1  parity bit present.
ParityEven  in  1  1=even parity, 0=odd parity.
RXD  in  1  asynchronous serial input; idles high.
RxBusy  out  1  frame reception in progress.
RxDone  out  1  frame complete; held DONE_HOLD clocks.
RxData  out  8  received byte, LSB-first on the line; unused upper bits are 0.
ParityError  out  1  parity mismatch on the last frame.
FramingError  out  1  stop bit sampled low on the last frame.
BreakInt  out  1  data, parity and stop bits all 0 on the last frame.

Behaviour:
- Reset: all outputs 0; RXD synchronizer flops = 1; state IDLE; tick counter = 0; line-armed flag = 1.
- RXD passes through a 2-flop synchronizer, and only the synchronized value is used (2-clock input latency).
- Tick generator: down-counter reloads BAUD_DIV, tick when it reaches 0. It runs only while RxEn=1 and is reloaded on start detection so phase aligns to the start edge. BAUD_DIV=0 gives a tick every clock.
- A 4-bit sample counter counts ticks within a bit. The mid-bit sample is taken at count 7 for the start bit, then every 16 ticks after that.
- FSM IDLE: requires line-armed=1 and a synced RXD 1->0 transition.
  - On detection: go to START, latch DataBits/ParityEn/ParityEven for the frame, RxBusy=1.
- FSM START: at mid-bit, RXD=1 is a false start: go to IDLE, RxBusy=0, no RxDone, no flag change. RXD=0 goes to DATA.
- FSM DATA: shift in N bits LSB first. After bit N, go to PARITY if ParityEn, else STOP.
- FSM PARITY: sample the parity bit. Error when (XOR of data bits XOR parity bit) is not equal to !ParityEven.
- FSM STOP: sample the stop bit (one stop bit checked; extra stop bits are treated as idle).
  - On the clock after this sample, update RxData, ParityError, FramingError (=!RXD) and BreakInt together.
  - In the same clock: RxBusy=0, RxDone=1, return to IDLE.
- RxData and flags hold until the next completed frame. A false start or disable never alters them.
- RxDone: an independent hold counter keeps it high exactly DONE_HOLD clocks. A new start detected during the hold is accepted, and the hold continues unaffected.
- Line-armed flag: cleared when the stop bit is sampled 0 (framing/break), set again once synced RXD=1. A held-low line therefore produces exactly one frame.
- RxEn=0 mid-frame: next clock goes to IDLE, RxBusy=0, counters cleared, no RxDone, outputs held. An RxDone hold already in progress completes.
- Async reset mid-frame: immediate return to reset values, with no partial byte delivered.

Test Plan:
- 8N1, BAUD_DIV=3 (64 clocks/bit), send 0xA5 -> RxBusy high from start detect to stop sample; RxData=0xA5; RxDone high 8 clocks; all flags 0.
- RXD low 20 clocks then high (glitch, shorter than the 32-clock half-bit) -> RxBusy pulses, returns 0 at mid-start, no RxDone, RxData unchanged.
- 7E1, send 0x41 with parity bit 1 (wrong) -> RxData=0x41, ParityError=1. Repeat with parity 0 -> ParityError=0.
- 8N1, 0x3C with stop bit 0 -> FramingError=1, BreakInt=0. RXD held low for 3 frame times -> one RxDone, RxData=0x00, BreakInt=1, FramingError=1, then no further frame until RXD returns high.
- Back-to-back 8N1 frames 0x55, 0xAA with a single stop bit -> two RxDone pulses, RxData 0x55 then 0xAA, flags 0.
- Assert RESETn low during the DATA bit 4 of a frame -> all outputs 0 immediately. After release, the next full frame 0x81 is received correctly.
